// File: rtl/des_dual_core.sv
// Iterative DES engine: encrypt and decrypt paths run side by side.
// Optional DES_KEY_PARITY_CHECK_EN adds the key_parity_err output.
`timescale 1ns/1ps
module des_dual_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr0,
  input  logic        wr1,
  input  logic        en,
  input  logic [63:0] key_in,
  input  logic [63:0] msg_in,
  input  logic [5:0]  add0,
  input  logic [5:0]  add1,
  output logic [63:0] Encrypt,
  output logic [63:0] Decrypt,
`ifdef DES_KEY_PARITY_CHECK_EN
  output logic        key_parity_err,
`endif
  output logic        out_valid
);
  localparam int ROUNDS = 16;
  localparam int DEPTH  = 64;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41, 9, 49, 17, 57, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9,
    1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27,
    19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
    7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29,
    21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5,
    3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8,
    16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32};
  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5,
    4, 5, 6, 7, 8, 9,
    8, 9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17,
    1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9,
    19, 13, 30, 6, 22, 11, 4, 25};
  localparam logic [2047:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] f_ip(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
    return o;
  endfunction

  function automatic logic [63:0] f_fp(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
    return o;
  endfunction

  function automatic logic [55:0] f_pc1(input logic [63:0] x);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = x[64-PC1_T[i]];
    return o;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2_T[i]];
    return o;
  endfunction

  function automatic logic [31:0] f_sp(input logic [31:0] r,
                                       input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] o;
    logic [5:0]  b;
    int          idx;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    for (int n = 0; n < 8; n++) begin
      b = x[47-6*n -: 6];
      idx = 64 * n + 16 * int'({b[5], b[0]}) + int'(b[4:1]);
      s[31-4*n -: 4] = SBOX[2047-4*idx -: 4];
    end
    for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
    return o;
  endfunction

  function automatic logic [63:0] f_round(input logic [63:0] lr,
                                          input logic [47:0] k);
    return {lr[31:0], lr[63:32] ^ f_sp(lr[31:0], k)};
  endfunction

  function automatic logic [55:0] rol(input logic [55:0] cd, input logic two);
    return two ? {cd[53:28], cd[55:54], cd[25:0], cd[27:26]}
               : {cd[54:28], cd[55], cd[26:0], cd[27]};
  endfunction

  function automatic logic [55:0] ror(input logic [55:0] cd, input logic two);
    return two ? {cd[29:28], cd[55:30], cd[1:0], cd[27:2]}
               : {cd[28], cd[55:29], cd[0], cd[27:1]};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  state_t      nxt;
  logic [4:0]  cnt;
  logic [63:0] key_mem [DEPTH];
  logic [63:0] msg_mem [DEPTH];
  logic [55:0] cd_e;
  logic [55:0] cd_d;
  logic [63:0] lr_e;
  logic [63:0] lr_d;
  logic [63:0] key_sel;
  logic [63:0] msg_sel;
  logic [55:0] cd_e_n;
  logic [55:0] cd_d_n;
  logic        one_e;
  logic        one_d;
  logic        start;

  // Write-first operand fetch: a same-cycle write feeds the engine directly.
  assign key_sel = wr0 ? key_in : key_mem[add0];
  assign msg_sel = wr1 ? msg_in : msg_mem[add1];

  // Decrypt starts on K16 (= C0/D0), then walks the schedule backwards.
  assign one_e  = cnt == 5'd1 || cnt == 5'd2 || cnt == 5'd9 || cnt == 5'd16;
  assign one_d  = cnt == 5'd2 || cnt == 5'd9 || cnt == 5'd16;
  assign cd_e_n = rol(cd_e, !one_e);
  assign cd_d_n = (cnt == 5'd1) ? cd_d : ror(cd_d, !one_d);

  // Memory write ports, active in every state.
  always_ff @(posedge clk) begin
    if (wr0) key_mem[add0] <= key_in;
    if (wr1) msg_mem[add1] <= msg_in;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state decode; en only matters in IDLE.
  always_comb begin
    nxt   = state;
    start = 1'b0;
    unique case (state)
      IDLE: if (en) begin
        nxt   = RUN;
        start = 1'b1;
      end
      RUN:  if (cnt == 5'(ROUNDS)) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Round datapath for both directions; no reset needed.
  always_ff @(posedge clk) begin
    if (start) begin
      cd_e <= f_pc1(key_sel);
      cd_d <= f_pc1(key_sel);
      lr_e <= f_ip(msg_sel);
      lr_d <= f_ip(msg_sel);
    end else if (state == RUN) begin
      cd_e <= cd_e_n;
      cd_d <= cd_d_n;
      lr_e <= f_round(lr_e, f_pc2(cd_e_n));
      lr_d <= f_round(lr_d, f_pc2(cd_d_n));
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic par_bad;

  // Flag a key byte with even parity at capture time.
  always_ff @(posedge clk) begin
    if (start) begin
      par_bad <= 1'b0;
      for (int b = 0; b < 8; b++)
        if (~^key_sel[8*b +: 8]) par_bad <= 1'b1;
    end
  end

  // Parity result is published alongside the data results.
  always_ff @(posedge clk) begin
    if (!rst_n)              key_parity_err <= 1'b0;
    else if (state == DONE)  key_parity_err <= par_bad;
  end
`endif

  // Round counter and registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      Encrypt   <= '0;
      Decrypt   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: if (start) cnt <= 5'd1;
        RUN:  cnt <= cnt + 5'd1;
        DONE: begin
          cnt       <= '0;
          Encrypt   <= f_fp({lr_e[31:0], lr_e[63:32]});
          Decrypt   <= f_fp({lr_d[31:0], lr_d[63:32]});
          out_valid <= 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_des_dual_core.sv
// Scoreboard bench for des_dual_core against a software DES model.
// Build with DES_KEY_PARITY_CHECK_EN to also check key_parity_err.
`timescale 1ns/1ps
module tb_des_dual_core;
  logic        clk;
  logic        rst_n;
  logic        wr0;
  logic        wr1;
  logic        en;
  logic [63:0] key_in;
  logic [63:0] msg_in;
  logic [5:0]  add0;
  logic [5:0]  add1;
  logic [63:0] enc_o;
  logic [63:0] dec_o;
  logic        out_valid;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic        par_o;
`endif

  des_dual_core dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr0(wr0),
    .wr1(wr1),
    .en(en),
    .key_in(key_in),
    .msg_in(msg_in),
    .add0(add0),
    .add1(add1),
    .Encrypt(enc_o),
    .Decrypt(dec_o),
`ifdef DES_KEY_PARITY_CHECK_EN
    .key_parity_err(par_o),
`endif
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Reference DES, written with FIPS bit numbering (bit 1 = MSB).
  function automatic logic [31:0] feistel(logic [31:0] r, logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] o;
    logic [5:0]  six;
    logic [255:0] box;
    int src, row, col;
    for (int g = 0; g < 8; g++)
      for (int p = 0; p < 6; p++) begin
        src = ((4 * g + p - 1 + 32) % 32) + 1;
        x[47 - (6 * g + p)] = r[32 - src];
      end
    x = x ^ k;
    for (int n = 0; n < 8; n++) begin
      six = x[47 - 6 * n -: 6];
      row = 2 * int'(six[5]) + int'(six[0]);
      col = int'(six[4:1]);
      box = SB[n];
      s[31 - 4 * n -: 4] = box[255 - 4 * (16 * row + col) -: 4];
    end
    for (int i = 1; i <= 32; i++) o[32 - i] = s[32 - P_T[i-1]];
    return o;
  endfunction

  function automatic logic [63:0] des_ref(logic [63:0] key,
                                          logic [63:0] blk, bit dec);
    logic [47:0] sk [16];
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [63:0] x, y;
    logic [31:0] l, r, t;
    int sh;
    for (int i = 1; i <= 56; i++) cd[56 - i] = key[64 - PC1_T[i-1]];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 1; i <= 16; i++) begin
      sh = (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
      for (int s = 0; s < sh; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 1; j <= 48; j++) sk[i-1][48 - j] = cd[56 - PC2_T[j-1]];
    end
    for (int i = 1; i <= 64; i++) x[64 - i] = blk[64 - IP_T[i-1]];
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ feistel(r, dec ? sk[15 - i] : sk[i]);
      l = t;
    end
    x = {r, l};
    // Final permutation as the inverse of IP.
    for (int i = 1; i <= 64; i++) y[64 - IP_T[i-1]] = x[64 - i];
    return y;
  endfunction

  function automatic logic bad_parity(logic [63:0] k);
    for (int b = 0; b < 8; b++)
      if (^k[8 * b +: 8] == 1'b0) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct {
    logic [63:0] enc;
    logic [63:0] dec;
    logic        par;
  } exp_t;

  exp_t        q [$];
  logic [63:0] kmem [64];
  logic [63:0] mmem [64];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [63:0] last_enc = '0;
  logic [63:0] last_dec = '0;
  logic        prev_v   = 1'b0;
  bit          gap_on   = 1'b0;
  longint      last_t   = -1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] want);
    chk_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
  endtask

  // Monitor: pop one expectation per out_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (prev_v) chk("pulse_width", 64'(out_valid), 64'd0);
    prev_v = out_valid & rst_n;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_valid: got pulse expected none at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("encrypt", enc_o, e.enc);
        chk("decrypt", dec_o, e.dec);
`ifdef DES_KEY_PARITY_CHECK_EN
        chk("parity", 64'(par_o), 64'(e.par));
`endif
        last_enc = e.enc;
        last_dec = e.dec;
        if (gap_on) begin
          if (last_t >= 0) chk("job_gap", 64'($time - last_t), 64'd180);
          last_t = $time;
        end
      end
    end
  end

  task automatic wr(logic kw, logic mw, logic [5:0] a0, logic [5:0] a1,
                    logic [63:0] k, logic [63:0] m);
    wr0 = kw; wr1 = mw; add0 = a0; add1 = a1; key_in = k; msg_in = m;
    if (kw) kmem[a0] = k;
    if (mw) mmem[a1] = m;
    @(posedge clk); #1;
    wr0 = 0; wr1 = 0;
  endtask

  function automatic void push(logic [63:0] k, logic [63:0] m);
    exp_t e;
    e.enc = des_ref(k, m, 1'b0);
    e.dec = des_ref(k, m, 1'b1);
    e.par = bad_parity(k);
    q.push_back(e);
  endfunction

  task automatic start(logic [5:0] a0, logic [5:0] a1);
    add0 = a0; add1 = a1; en = 1;
    push(kmem[a0], mmem[a1]);
    @(posedge clk); #1;
    en = 0;
  endtask

  task automatic override(logic [63:0] enc, logic [63:0] dec,
                          bit ue, bit ud);
    exp_t e;
    e = q.pop_back();
    if (ue) e.enc = enc;
    if (ud) e.dec = dec;
    q.push_back(e);
  endtask

  task automatic wait_q();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk_cnt++;
      $display("FAIL wait_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    #1;
  endtask

  initial begin
    logic [63:0] k, m;
    logic [5:0]  a0, a1;
    clk = 0; rst_n = 0; wr0 = 0; wr1 = 0; en = 0;
    key_in = '0; msg_in = '0; add0 = '0; add1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_enc", enc_o, 64'd0);
    chk("reset_dec", dec_o, 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // Known-answer vectors.
    wr(1, 0, 0, 0, 64'h133457799BBCDFF1, '0);
    wr(0, 1, 0, 5, '0, 64'h0123456789ABCDEF);
    wr(0, 1, 0, 11, '0, 64'h85E813540F0AB405);
    start(0, 5);
    override(64'h85E813540F0AB405, '0, 1, 0);
    wait_q();
    start(0, 11);
    override('0, 64'h0123456789ABCDEF, 0, 1);
    wait_q();
    wr(1, 0, 1, 0, 64'h0E329232EA6D0D73, '0);
    wr(0, 1, 0, 6, '0, 64'h8787878787878787);
    wr(0, 1, 0, 7, '0, 64'h0000000000000000);
    start(1, 6);
    override(64'h0000000000000000, '0, 1, 0);
    wait_q();
    start(1, 7);
    override('0, 64'h8787878787878787, 0, 1);
    wait_q();

    // Outputs hold after the pulse.
    repeat (3) @(negedge clk);
    chk("hold_enc", enc_o, last_enc);
    chk("hold_dec", dec_o, last_dec);
    @(posedge clk); #1;

    // Write-first bypass on a start cycle.
    wr(1, 1, 2, 8, {$urandom, $urandom}, {$urandom, $urandom});
    k = {$urandom, $urandom};
    m = {$urandom, $urandom};
    wr0 = 1; wr1 = 1; en = 1; add0 = 2; add1 = 8;
    key_in = k; msg_in = m;
    kmem[2] = k; mmem[8] = m;
    push(k, m);
    @(posedge clk); #1;
    wr0 = 0; wr1 = 0; en = 0;
    wait_q();

    // Writes during RUN leave the in-flight job alone.
    wr(1, 1, 3, 9, {$urandom, $urandom}, {$urandom, $urandom});
    start(3, 9);
    repeat (5) @(posedge clk); #1;
    wr(1, 1, 3, 9, {$urandom, $urandom}, {$urandom, $urandom});
    wait_q();
    start(3, 9);
    wait_q();

    // Reset during round 8, then rerun from retained memory.
    start(0, 5);
    repeat (7) @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    q.delete();
    @(negedge clk);
    chk("midrst_enc", enc_o, 64'd0);
    chk("midrst_dec", dec_o, 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (25) @(posedge clk); #1;
    start(0, 5);
    override(64'h85E813540F0AB405, '0, 1, 0);
    wait_q();

    // Random jobs.
    for (int i = 0; i < 6; i++) begin
      a0 = 6'($urandom_range(0, 63));
      a1 = 6'($urandom_range(0, 63));
      wr(1, 1, a0, a1, {$urandom, $urandom}, {$urandom, $urandom});
      start(a0, a1);
      wait_q();
    end

    // Back-to-back with en held high.
    for (int j = 0; j < 5; j++)
      wr(1, 1, 6'(j), 6'(5 + 6 * j), {$urandom, $urandom},
         {$urandom, $urandom});
    gap_on = 1;
    last_t = -1;
    en = 1;
    for (int j = 0; j < 5; j++) begin
      add0 = 6'(j);
      add1 = 6'(5 + 6 * j);
      push(kmem[j], mmem[5 + 6 * j]);
      @(posedge clk); #1;
      if (j == 4) en = 0;
      else begin
        repeat (17) @(posedge clk);
        #1;
      end
    end
    wait_q();
    gap_on = 0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
